muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit in the execute stage, fed by the ID/EX register (rdata1E, rdata2E, funct3E).

---
 rtl/muldiv_pkg.sv | 18 +
 rtl/muldiv_iter.sv | 22 ++
 rtl/muldiv_unit.sv | 109 ++++++++++
 tb/tb_muldiv_unit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the RV32M multiply/divide unit
package muldiv_pkg;
  localparam int MD_XLEN = 32;
  localparam int MD_ITER = 32;
  localparam int MD_CW = $clog2(MD_ITER);
  localparam logic [MD_XLEN-1:0] DIV0_QUOT = '1;
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_e;
  typedef enum logic [1:0] {IDLE, CALC, DONE} md_state_e;
endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: one radix-2 iteration on the packed {hi, lo} accumulator
// Ports: i_div selects restoring-divide step (else shift-add multiply step);
//        i_acc current accumulator, i_b multiplicand/divisor magnitude, o_acc next accumulator.
// Multiply: lo holds the remaining multiplier bits, hi the partial product.
// Divide:   lo holds dividend bits shifting out / quotient bits shifting in, hi the remainder.
module muldiv_iter import muldiv_pkg::*; #(
  parameter int XLEN = MD_XLEN
) (
  input  logic              i_div,
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [XLEN-1:0]   i_b,
  output logic [2*XLEN-1:0] o_acc
);
  logic [XLEN:0] w_sum, w_sh, w_diff;
  assign w_sum  = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_acc[0] ? {1'b0, i_b} : '0);
  assign w_sh   = i_acc[2*XLEN-1:XLEN-1];
  // sh < 2*b, so the top bit of the difference is a reliable borrow flag
  assign w_diff = w_sh - {1'b0, i_b};
  assign o_acc  = !i_div     ? {w_sum, i_acc[XLEN-1:1]} :
                  w_diff[XLEN] ? {w_sh[XLEN-1:0], i_acc[XLEN-2:0], 1'b0} :
                                 {w_diff[XLEN-1:0], i_acc[XLEN-2:0], 1'b1};
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the execute stage
// Ports: clk, rst (async active-low), start (RV32M op in EX), kill (flush EX),
//        funct3E (op select), op_a/op_b (rs1/rs2), stall (hold upstream),
//        done (one-cycle result valid), result (registered result).
// Option: MULDIV_FAST_MUL_EN resolves MUL* in one cycle with a combinational multiplier.
module muldiv_unit import muldiv_pkg::*; #(
  parameter int XLEN = MD_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3E,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);
  md_state_e         r_state, w_next;
  md_op_e            r_op, w_op;
  logic [XLEN-1:0]   r_b;
  logic [2*XLEN-1:0] r_acc, w_acc_step, w_prod;
  logic [MD_CW-1:0]  r_cnt;
  logic              r_neg_q, r_neg_r;
  logic              w_is_div, w_sa, w_sb, w_neg_a, w_neg_b, w_div0, w_ovf;
  logic              w_issue, w_direct, w_fast, w_last;
  logic [XLEN-1:0]   w_mag_a, w_mag_b, w_spec_res, w_fast_res, w_direct_res;
  logic [XLEN-1:0]   w_quot, w_rem, w_calc_res;

  assign w_op     = md_op_e'(funct3E);
  assign w_is_div = funct3E[2];
  // MUL low word is sign-agnostic, so it shares the signed path
  assign w_sa     = !(w_op inside {OP_MULHU, OP_DIVU, OP_REMU});
  assign w_sb     = w_op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  assign w_neg_a  = w_sa & op_a[XLEN-1];
  assign w_neg_b  = w_sb & op_b[XLEN-1];
  assign w_mag_a  = w_neg_a ? -op_a : op_a;
  assign w_mag_b  = w_neg_b ? -op_b : op_b;
  assign w_div0   = w_is_div & (op_b == '0);
  assign w_ovf    = (w_op inside {OP_DIV, OP_REM}) & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (op_b == '1);
  // on overflow op_a is the most-negative value, which is exactly the DIV result
  assign w_spec_res = w_div0 ? (funct3E[1] ? op_a : DIV0_QUOT) : (funct3E[1] ? '0 : op_a);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fast_prod;
  // 33-bit signed operands sign-extended to 64 bits; the product's low 64 bits are exact
  assign w_fast_prod = {{XLEN{w_neg_a}}, op_a} * {{XLEN{w_neg_b}}, op_b};
  assign w_fast      = !w_is_div;
  assign w_fast_res  = (w_op == OP_MUL) ? w_fast_prod[XLEN-1:0] : w_fast_prod[2*XLEN-1:XLEN];
`else
  assign w_fast      = 1'b0;
  assign w_fast_res  = '0;
`endif

  assign w_issue      = (r_state == IDLE) & start & !kill;
  assign w_direct     = w_is_div ? (w_div0 | w_ovf) : w_fast;
  assign w_direct_res = w_is_div ? w_spec_res : w_fast_res;
  assign w_last       = r_cnt == MD_CW'(MD_ITER - 1);

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .i_div (r_op[2]),
    .i_acc (r_acc),
    .i_b   (r_b),
    .o_acc (w_acc_step)
  );

  // the final iteration lands in the same cycle the result is captured
  assign w_prod     = r_neg_q ? -w_acc_step : w_acc_step;
  assign w_quot     = r_neg_q ? -w_acc_step[XLEN-1:0] : w_acc_step[XLEN-1:0];
  assign w_rem      = r_neg_r ? -w_acc_step[2*XLEN-1:XLEN] : w_acc_step[2*XLEN-1:XLEN];
  assign w_calc_res = !r_op[2] ? ((r_op == OP_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]) :
                      r_op[1] ? w_rem : w_quot;

  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;

  always_comb begin
    w_next = kill ? IDLE :
             (r_state == IDLE) ? (start ? (w_direct ? DONE : CALC) : IDLE) :
             (r_state == CALC) ? (w_last ? DONE : CALC) : IDLE;
    stall  = rst & (w_issue | (r_state == CALC));
    done   = (r_state == DONE) & !kill;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_op    <= OP_MUL;
      r_b     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      result  <= '0;
    end else if (w_issue) begin
      r_op    <= w_op;
      r_b     <= w_mag_b;
      r_acc   <= {{XLEN{1'b0}}, w_mag_a};
      r_cnt   <= '0;
      r_neg_q <= w_neg_a ^ w_neg_b;
      r_neg_r <= w_neg_a;
      if (w_direct) result <= w_direct_res;
    end else if (r_state == CALC) begin
      r_acc <= w_acc_step;
      r_cnt <= r_cnt + MD_CW'(1);
      if (!kill && w_last) result <= w_calc_res;
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit with a behavioural RV32M reference
module tb_muldiv_unit;
  logic        clk = 0, rst = 0, start = 0, kill = 0;
  logic [2:0]  funct3E = 0;
  logic [31:0] op_a = 0, op_b = 0;
  logic        stall, done;
  logic [31:0] result;

  typedef struct {logic [31:0] res; int lat; int cyc;} exp_t;
  exp_t        q[$];
  int          n_cmp = 0, n_bad = 0, cyc = 0, scnt = 0;
  logic [31:0] last_res = 0;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .kill(kill), .funct3E(funct3E),
    .op_a(op_a), .op_b(op_b), .stall(stall), .done(done), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint pa, pb;
    logic [63:0] p;
    int sa, sb;
    if (!f[2]) begin
      pa = (f == 3'b011) ? longint'(a) : longint'($signed(a));
      pb = (f[1]) ? longint'(b) : longint'($signed(b));
      p = pa * pb;
      return (f == 3'b000) ? p[31:0] : p[63:32];
    end
    if (b == 0) return f[1] ? a : 32'hFFFFFFFF;
    if (!f[0]) begin
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) return f[1] ? 32'h0 : 32'h80000000;
      sa = a;
      sb = b;
      return f[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return f[1] ? a % b : a / b;
  endfunction

  function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) return 1;
`ifdef MULDIV_FAST_MUL_EN
    return f[2] ? 33 : 1;
`else
    return 33;
`endif
  endfunction

  always @(negedge clk) begin
    if (!rst || kill) scnt = 0;
    else begin
      if (stall) scnt++;
      if (done) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done=1 expected none, result %h", result);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("result", result, e.res);
          chk("done_latency", 32'(cyc - e.cyc), 32'(e.lat));
          chk("stall_cycles", 32'(scnt), 32'(e.lat));
          chk("stall_at_done", {31'b0, stall}, 32'h0);
          last_res = e.res;
        end
        scnt = 0;
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: got no done after %0d cycles expected done", k);
      q.delete();
    end
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    start = 1; funct3E = f; op_a = a; op_b = b;
    q.push_back('{model(f, a, b), latency(f, a, b), cyc});
    @(posedge clk);
    #1;
    start = 0; funct3E = 3'($urandom); op_a = $urandom; op_b = $urandom;
    wait_idle();
  endtask

  initial begin
    #2;
    chk("reset_stall", {31'b0, stall}, 32'h0);
    chk("reset_done", {31'b0, done}, 32'h0);
    chk("reset_result", result, 32'h0);
    #20 rst = 1;
    issue(3'b000, 32'h00000007, 32'hFFFFFFFD);
    issue(3'b001, 32'h80000000, 32'h80000000);
    issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue(3'b100, 32'hFFFFFFEC, 32'h00000003);
    issue(3'b110, 32'hFFFFFFEC, 32'h00000003);
    issue(3'b101, 32'd100, 32'd7);
    issue(3'b111, 32'd100, 32'd7);
    issue(3'b100, 32'd5, 32'd0);
    issue(3'b111, 32'd5, 32'd0);
    issue(3'b100, 32'h80000000, 32'hFFFFFFFF);
    issue(3'b110, 32'h80000000, 32'hFFFFFFFF);
    // kill during the 10th CALC cycle of a divide
    @(posedge clk);
    #1;
    start = 1; funct3E = 3'b101; op_a = 32'd1000; op_b = 32'd3;
    @(posedge clk);
    #1;
    start = 0;
    repeat (9) @(posedge clk);
    #1;
    kill = 1;
    @(posedge clk);
    #1;
    kill = 0;
    chk("kill_idle_stall", {31'b0, stall}, 32'h0);
    chk("kill_result_held", result, last_res);
    repeat (40) @(posedge clk);
    #1;
    chk("kill_result_later", result, last_res);
    // start and kill together
    start = 1; kill = 1; funct3E = 3'b100; op_a = 32'd9; op_b = 32'd0;
    #1;
    chk("startkill_stall", {31'b0, stall}, 32'h0);
    @(posedge clk);
    #1;
    start = 0; kill = 0;
    chk("startkill_idle", {31'b0, stall}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("startkill_result", result, last_res);
    // async reset mid-CALC
    @(posedge clk);
    #1;
    start = 1; funct3E = 3'b101; op_a = 32'd12345; op_b = 32'd7;
    @(posedge clk);
    #1;
    start = 0;
    repeat (5) @(posedge clk);
    #3;
    rst = 0;
    #1;
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_result", result, 32'h0);
    @(negedge clk);
    #1;
    rst = 1;
    repeat (40) @(posedge clk);
    #1;
    chk("rst_no_done_result", result, 32'h0);
    // randomized operations
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      f = 3'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 0;
        1: b = 32'($urandom_range(1, 15));
        2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        default: ;
      endcase
      issue(f, a, b);
    end
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
